// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter and its embedded 8-bit ALU.
package alu_pkg;

   localparam int ALU_W = 8;

   typedef enum logic [2:0] {
      ADD = 3'b000,
      SUB = 3'b001,
      INC = 3'b010,
      DEC = 3'b011,
      AND = 3'b100,
      OR  = 3'b101,
      XOR = 3'b110,
      NOT = 3'b111
   } alu_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } alu_arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU: wrap-around arithmetic and bitwise ops, no carry out.
module alu_arbiter_alu
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  alu_mode_t        mode,
   output logic [ALU_W-1:0] y
);

   always_comb begin
      y = '0;
      unique case (mode)
         ADD:     y = a + b;
         SUB:     y = a - b;
         INC:     y = a + 1'b1;
         DEC:     y = a - 1'b1;
         AND:     y = a & b;
         OR:      y = a | b;
         XOR:     y = a ^ b;
         NOT:     y = ~a;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between N_REQ valid/ready requesters,
// with a one-deep registered response and a saturating completion counter.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [ALU_W*N_REQ-1:0] req_a,
   input  logic [ALU_W*N_REQ-1:0] req_b,
   input  logic [3*N_REQ-1:0]     req_mode,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ALU_W-1:0]       rsp_data,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   busy,
   output logic [CNT_W-1:0]       op_count
);

   // Returns {found, index}: first valid requester strictly after ptr, wrapping.
   function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                             input logic [ID_W-1:0]  ptr);
      logic            found;
      logic [ID_W-1:0] idx;
      int              cand;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = (int'(ptr) + k) % N_REQ;
         if (!found && valid[cand]) begin
            found = 1'b1;
            idx   = ID_W'(cand);
         end
      end
      return {found, idx};
   endfunction

   alu_arb_state_t   state_q,     state_d;
   logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
   logic [ALU_W-1:0] a_q,         a_d;
   logic [ALU_W-1:0] b_q,         b_d;
   alu_mode_t        mode_q,      mode_d;
   logic [ID_W-1:0]  id_q,        id_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [ALU_W-1:0] rsp_data_q,  rsp_data_d;
   logic [ID_W-1:0]  rsp_id_q,    rsp_id_d;
   logic [CNT_W-1:0] op_count_q,  op_count_d;

   logic [ID_W:0]    pick;
   logic             pick_found;
   logic [ID_W-1:0]  pick_idx;
   logic [ALU_W-1:0] alu_y;

   assign pick       = rr_pick(req_valid, rr_ptr_q);
   assign pick_found = pick[ID_W];
   assign pick_idx   = pick[ID_W-1:0];

   alu_arbiter_alu u_alu (
      .a    (a_q),
      .b    (b_q),
      .mode (mode_q),
      .y    (alu_y)
   );

   always_comb begin
      // NOTE: every _d starts from its _q so no branch leaves a value unassigned
      // and no latch is inferred.
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      a_d         = a_q;
      b_d         = b_q;
      mode_d      = mode_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      op_count_d  = op_count_q;
      req_ready   = '0;

      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               req_ready[pick_idx] = 1'b1;
               a_d      = req_a[ALU_W*pick_idx +: ALU_W];
               b_d      = req_b[ALU_W*pick_idx +: ALU_W];
               mode_d   = alu_mode_t'(req_mode[3*pick_idx +: 3]);
               id_d     = pick_idx;
               rr_ptr_d = pick_idx;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            rsp_data_d  = alu_y;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
               // Saturate rather than wrap so a long run never reads as few ops.
               if (op_count_q != {CNT_W{1'b1}})
                  op_count_d = op_count_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= ID_W'(N_REQ - 1);
         a_q         <= '0;
         b_q         <= '0;
         mode_q      <= ADD;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         a_q         <= a_d;
         b_q         <= b_d;
         mode_q      <= mode_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         op_count_q  <= op_count_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign op_count  = op_count_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected responses,
// a monitor pops and compares on every response handshake.
module tb_alu_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [5:0]  req_mode;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic [0:0]  rsp_id;
   logic        busy;
   logic [15:0] op_count;

   logic [1:0]  req_valid4;
   logic [1:0]  req_ready4;
   logic        rsp_valid4;
   logic        rsp_ready4;
   logic [7:0]  rsp_data4;
   logic [0:0]  rsp_id4;
   logic        busy4;
   logic [3:0]  op_count4;

   alu_arbiter #(.N_REQ(2), .ID_W(1), .CNT_W(16)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_mode  (req_mode),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy),
      .op_count  (op_count)
   );

   alu_arbiter #(.N_REQ(2), .ID_W(1), .CNT_W(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid4),
      .req_ready (req_ready4),
      .req_a     (16'h0101),
      .req_b     (16'h0101),
      .req_mode  (6'b000000),
      .rsp_valid (rsp_valid4),
      .rsp_ready (rsp_ready4),
      .rsp_data  (rsp_data4),
      .rsp_id    (rsp_id4),
      .busy      (busy4),
      .op_count  (op_count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [0:0] id;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cycle    = 0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycle);
   endtask

   // Monitor: response comparison and ready legality, sampled on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("ready_legal", busy ? (req_ready == 2'b00) : $onehot0(req_ready), 1);
            if (rsp_valid && rsp_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_rsp", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("rsp_id", rsp_id, e.id);
                  check("rsp_data", rsp_data, e.data);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] m);
      req_a[8*i +: 8]    = a;
      req_b[8*i +: 8]    = b;
      req_mode[3*i +: 3] = m;
   endtask

   task automatic expect_rsp(input int id, input logic [7:0] d);
      exp_t e;
      e.id   = 1'(id);
      e.data = d;
      sb.push_back(e);
   endtask

   // Waits for a grant, checks it, returns just after the accepting edge.
   task automatic wait_grant(input logic [1:0] exp, output int cyc_at);
      int n;
      n = 0;
      @(negedge clk);
      while (req_ready == 2'b00 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("grant", req_ready, exp);
      cyc_at = cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Single request on lane i with response-latency checks; rsp_ready must be 1.
   task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] m, input logic [7:0] exp);
      int t;
      set_lane(i, a, b, m);
      expect_rsp(i, exp);
      req_valid[i] = 1'b1;
      wait_grant(2'b01 << i, t);
      req_valid[i] = 1'b0;
      @(negedge clk);
      check("latency_exec_no_rsp", rsp_valid, 0);
      check("busy_exec", busy, 1);
      @(negedge clk);
      check("latency_rsp_valid", rsp_valid, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] mode_exp [8];
      int t, prev, n;
      mode_exp = '{8'h01, 8'hFF, 8'h01, 8'hFF, 8'h00, 8'h01, 8'h01, 8'hFF};

      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_mode = '0; rsp_ready = 1'b1;
      req_valid4 = '0; rsp_ready4 = 1'b1;
      do_reset();

      // Reset state
      @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_op_count", op_count, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);

      // 1: single ADD on requester 0
      @(posedge clk); #1;
      issue(0, 8'hF0, 8'h20, 3'b000, 8'h10);

      // 2: all modes on requester 1
      do_reset();
      for (int m = 0; m < 8; m++) issue(1, 8'h00, 8'h01, 3'(m), mode_exp[m]);
      @(negedge clk);
      check("op_count_after_modes", op_count, 8);

      // 3: both requesting continuously -> 0,1,0,1, one accept per 3 cycles
      @(posedge clk); #1;
      set_lane(0, 8'h05, 8'h03, 3'b000);
      set_lane(1, 8'h05, 8'h03, 3'b001);
      for (int k = 0; k < 4; k++) expect_rsp(k % 2, (k % 2 == 0) ? 8'h08 : 8'h02);
      req_valid = 2'b11;
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         wait_grant((k % 2 == 0) ? 2'b01 : 2'b10, t);
         if (k > 0) check("issue_interval", t - prev, 3);
         prev = t;
      end
      req_valid = 2'b00;
      drain();

      // 4: back-pressure in RESP with both valid
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      set_lane(0, 8'h11, 8'h22, 3'b101);
      set_lane(1, 8'h0F, 8'hF0, 3'b110);
      expect_rsp(0, 8'h33);
      req_valid = 2'b11;
      wait_grant(2'b01, t);
      @(negedge clk);
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_rsp_data_stable", rsp_data, 8'h33);
         check("bp_rsp_id_stable", rsp_id, 0);
         check("bp_req_ready_zero", req_ready, 2'b00);
      end
      expect_rsp(1, 8'hFF);
      expect_rsp(0, 8'h33);
      @(posedge clk); #1 rsp_ready = 1'b1;
      wait_grant(2'b10, t);
      wait_grant(2'b01, t);
      req_valid = 2'b00;
      drain();

      // 5a: reset while in EXEC
      @(posedge clk); #1;
      req_valid = 2'b01;
      wait_grant(2'b01, t);
      req_valid = 2'b00;
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst_exec_busy", busy, 0);
      check("rst_exec_rsp_valid", rsp_valid, 0);
      check("rst_exec_op_count", op_count, 0);
      check("rst_exec_rsp_data", rsp_data, 0);

      // 5b: reset while in RESP
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 2'b10;
      wait_grant(2'b10, t);
      req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_rsp_valid", rsp_valid, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst_resp_busy", busy, 0);
      check("rst_resp_rsp_valid", rsp_valid, 0);
      check("rst_resp_op_count", op_count, 0);
      check("rst_resp_rsp_data", rsp_data, 0);

      // 5c: after reset, requester 0 wins first
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      set_lane(0, 8'h05, 8'h03, 3'b000);
      set_lane(1, 8'h05, 8'h03, 3'b001);
      expect_rsp(0, 8'h08);
      expect_rsp(1, 8'h02);
      req_valid = 2'b11;
      wait_grant(2'b01, t);
      wait_grant(2'b10, t);
      req_valid = 2'b00;
      drain();

      // 6: saturation on the CNT_W=4 instance
      req_valid4 = 2'b01;
      n = 0;
      for (int c = 0; c < 200 && n < 17; c++) begin
         @(negedge clk);
         if (rsp_valid4 && rsp_ready4) begin
            check("sat_rsp_data", rsp_data4, 8'h02);
            n++;
            @(negedge clk);
            if (n == 14) check("sat_count_14", op_count4, 4'hE);
            if (n == 15) check("sat_count_15", op_count4, 4'hF);
            if (n == 16) check("sat_count_16", op_count4, 4'hF);
            if (n == 17) check("sat_count_17", op_count4, 4'hF);
         end
      end
      check("sat_ops_completed", n, 17);
      req_valid4 = 2'b00;

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
